miim_master: RTL and testbench
==============================

Name: miim_master

Overview:
- Serial MDIO/MDC management-interface master sitting directly downstream of the PHY configuration sequencer.
- Accepts single-cycle read/write requests (PHY address, register address, write data) and serialises each into a clause-22 management frame on MDC/MDIO.
- Reports busy while a frame is in flight; returns read data with a valid strobe and a no-response error flag.
- MDIO is split into mdio_o / mdio_oe / mdio_i; the tristate buffer lives at the top level.

Parameters:
CLK_DIV, 10, clk cycles per MDC half-period (>=1); one MDIO bit = 2*CLK_DIV clk cycles
PREAMBLE_LEN, 32, number of leading '1' preamble bits (1..32)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
miim_phyad  input  5  target PHY address
miim_regad  input  5  target register address
miim_wrdata  input  16  write data
miim_wren  input  1  one-cycle write request pulse
miim_rden  input  1  one-cycle read request pulse
busy  output  1  frame in progress
miim_rddata  output  16  last read data
miim_rddata_valid  output  1  one-cycle strobe when miim_rddata updates
miim_rderr  output  1  last read got no PHY turnaround response
mdc  output  1  management clock
mdio_o  output  1  MDIO drive value
mdio_oe  output  1  MDIO drive enable, 1 = master drives
mdio_i  input  1  MDIO sampled value

Behaviour:
- Reset, async, applies immediately, including mid-frame:
  - FSM goes to IDLE.
  - busy=0, mdc=0, mdio_o=1, mdio_oe=0.
  - miim_rddata=0, miim_rddata_valid=0, miim_rderr=0.
  - Bit and divider counters cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - mdc=0, mdio_oe=0, busy=0.
  - On a clk edge with miim_wren or miim_rden high, latch phyad, regad, wrdata and op into internal registers, then go to SHIFT.
  - busy must read 1 in the cycle immediately after the request pulse. The upstream sequencer checks busy one cycle after pulsing.
  - If wren and rden are both high, write wins and rden is ignored.
  - Requests arriving outside IDLE (SHIFT or DONE) are dropped with no effect.
- Frame length: N = PREAMBLE_LEN + 32 bits, sent MSB-first in this order:
  - PREAMBLE_LEN x '1'
  - ST = 01
  - OP = 01 (write) or 10 (read)
  - PHYAD[4:0]
  - REGAD[4:0]
  - TA
  - DATA[15:0]
- Bit timing:
  - Each bit is a low half (CLK_DIV cycles, mdc=0) followed by a high half (CLK_DIV cycles, mdc=1).
  - mdio_o / mdio_oe change only on the first cycle of the low half, i.e. as mdc falls. This gives the PHY CLK_DIV cycles of setup before the mdc rising edge.
- Write frame:
  - mdio_oe=1 for all N bits.
  - TA driven as 1,0.
  - Data bits driven from the latched wrdata.
- Read frame:
  - mdio_oe=1 through REGAD; mdio_oe=0 from the first TA bit to the end of the frame.
  - mdio_i sampled on the last clk cycle of each bit's low half (the cycle before mdc rises) for the second TA bit and all 16 data bits.
  - Data shifted in MSB-first.
  - Second TA bit sampled as 1: rderr_pending=1.
- SHIFT→DONE after the high half of bit N-1 completes, with mdc returning to 0.
- DONE (exactly 1 cycle):
  - busy=1, mdio_oe=0.
  - Read: miim_rddata <= shifted data, miim_rderr <= rderr_pending, miim_rddata_valid=1 for this cycle only.
  - Write: rddata, rderr and valid unchanged/0.
  - Next state IDLE.
- busy is high for exactly N*2*CLK_DIV + 1 cycles per frame.
  - Default: 64*20+1 = 1281.
  - CLK_DIV=4: 513.
- Counters:
  - Divider width is clog2(CLK_DIV), minimum 1 bit.
  - Bit counter is 6 bits, counts 0..N-1, and does not wrap beyond N-1.
- A new request may be accepted in the first IDLE cycle after DONE, so back-to-back frames are separated by one idle cycle.

Test Plan:
1. CLK_DIV=4, wren pulse with phyad=0, regad=0, wrdata=0x0044:
   - Sampled on mdc rising edges: 32x'1', 01, 01, 00000, 00000, 10, 0000000001000100.
   - mdio_oe=1 throughout.
   - busy=1 for 513 cycles, asserted in the cycle after the pulse.
2. rden with phyad=0, regad=2; PHY model drives TA-bit2=0 and data 0x0283:
   - miim_rddata=0x0283 and miim_rddata_valid high for exactly 1 cycle.
   - miim_rderr=0.
   - mdio_oe=0 from bit 46 to 63.
3. Read with mdio_i held at 1 (no PHY) -> miim_rddata=0xFFFF, miim_rderr=1, valid pulses once.
4. Contention:
   - wren pulse during bit 20 of an active frame -> ignored; exactly one frame is emitted.
   - Simultaneous wren+rden in IDLE -> write frame (OP=01) only.
5. rst asserted during bit 20:
   - Same cycle: busy=0, mdc=0, mdio_oe=0, mdio_o=1.
   - After release, a new write produces a complete, correct 64-bit frame.
6. Three sequenced requests (write reg0=0x0044, read reg2, read reg0) issued on each busy fall:
   - Three frames, each separated by 1 idle cycle.
   - The read of reg0 returns the PHY model's stored 0x0044.

Source files
------------

// File: rtl/miim_master.sv
// miim_master
// Clause-22 MDIO/MDC management master. A single-cycle read or write request
// is serialised into a management frame (preamble, ST, OP, PHYAD, REGAD, TA,
// DATA). On reads, the PHY's turnaround bit and data are shifted back in.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   miim_phyad/regad    target PHY and register address
//   miim_wrdata         write data
//   miim_wren/rden      one-cycle request pulses (write wins if both are high)
//   busy                high from the cycle after a request through DONE
//   miim_rddata         last read data
//   miim_rddata_valid   one-cycle strobe when miim_rddata updates
//   miim_rderr          last read saw no PHY drive on the second TA bit
//   mdc                 management clock
//   mdio_o/mdio_oe      MDIO drive value / drive enable (1 = master drives)
//   mdio_i              MDIO value seen at the pad
module miim_master #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  miim_phyad,
  input  logic [4:0]  miim_regad,
  input  logic [15:0] miim_wrdata,
  input  logic        miim_wren,
  input  logic        miim_rden,
  output logic        busy,
  output logic [15:0] miim_rddata,
  output logic        miim_rddata_valid,
  output logic        miim_rderr,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int N  = PREAMBLE_LEN + 32;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [5:0] PRE      = 6'(PREAMBLE_LEN);
  localparam logic [5:0] BIT_LAST = 6'(N - 1);
  localparam logic [5:0] TA1      = 6'(PREAMBLE_LEN + 14);
  localparam logic [5:0] TA2      = 6'(PREAMBLE_LEN + 15);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_nxt;
  logic          half_hi;
  logic          is_read;
  logic [31:0]   hdr;       // everything after the preamble, MSB sent first
  logic [15:0]   rx_sr;
  logic          rderr_pending;

  assign bit_nxt = bit_cnt + 6'd1;

  // Frame bit k: preamble ones, then the latched header MSB-first.
  function automatic logic bit_val(input logic [5:0] k, input logic [31:0] h);
    logic [5:0] off;
    off = k - PRE;
    if (k < PRE) return 1'b1;
    return h[5'd31 - off[4:0]];
  endfunction

  // Reads release the bus from the first TA bit onward.
  function automatic logic oe_val(input logic [5:0] k, input logic rd);
    if (!rd) return 1'b1;
    return (k < TA1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      mdc               <= 1'b0;
      mdio_o            <= 1'b1;
      mdio_oe           <= 1'b0;
      miim_rddata       <= '0;
      miim_rddata_valid <= 1'b0;
      miim_rderr        <= 1'b0;
      div_cnt           <= '0;
      bit_cnt           <= '0;
      half_hi           <= 1'b0;
      is_read           <= 1'b0;
      hdr               <= '0;
      rx_sr             <= '0;
      rderr_pending     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy              <= 1'b0;
          mdc               <= 1'b0;
          mdio_o            <= 1'b1;
          mdio_oe           <= 1'b0;
          miim_rddata_valid <= 1'b0;
          if (miim_wren || miim_rden) begin
            is_read       <= ~miim_wren;
            hdr           <= {2'b01, (miim_wren ? 2'b01 : 2'b10), miim_phyad,
                              miim_regad, 2'b10, miim_wrdata};
            state         <= SHIFT;
            busy          <= 1'b1;
            // bit 0 is always a preamble '1', driven as the first low half starts
            mdio_o        <= 1'b1;
            mdio_oe       <= 1'b1;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            half_hi       <= 1'b0;
            rx_sr         <= '0;
            rderr_pending <= 1'b0;
          end
        end

        SHIFT: begin
          // Sample on the last low-half cycle, just before mdc rises.
          if (!half_hi && div_cnt == DIV_LAST && is_read) begin
            if (bit_cnt == TA2)
              rderr_pending <= mdio_i;
            else if (bit_cnt > TA2)
              rx_sr <= {rx_sr[14:0], mdio_i};
          end

          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!half_hi) begin
              half_hi <= 1'b1;
              mdc     <= 1'b1;
            end else begin
              half_hi <= 1'b0;
              mdc     <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state   <= DONE;
                mdio_oe <= 1'b0;
                mdio_o  <= 1'b1;
                if (is_read) begin
                  miim_rddata       <= rx_sr;
                  miim_rderr        <= rderr_pending;
                  miim_rddata_valid <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_nxt;
                mdio_o  <= bit_val(bit_nxt, hdr);
                mdio_oe <= oe_val(bit_nxt, is_read);
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        DONE: begin
          busy              <= 1'b0;
          mdio_oe           <= 1'b0;
          miim_rddata_valid <= 1'b0;
          state             <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miim_master.sv
// Directed bench for miim_master (CLK_DIV=4, 32-bit preamble) with a small
// clause-22 PHY model at address 0 that captures frames on mdc rising edges.
module tb_miim_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  miim_phyad = '0;
  logic [4:0]  miim_regad = '0;
  logic [15:0] miim_wrdata = '0;
  logic        miim_wren = 1'b0;
  logic        miim_rden = 1'b0;
  logic        busy;
  logic [15:0] miim_rddata;
  logic        miim_rddata_valid;
  logic        miim_rderr;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i = 1'b1;

  int total = 0;
  int bad = 0;

  miim_master #(.CLK_DIV(4), .PREAMBLE_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .miim_phyad(miim_phyad), .miim_regad(miim_regad), .miim_wrdata(miim_wrdata),
    .miim_wren(miim_wren), .miim_rden(miim_rden),
    .busy(busy), .miim_rddata(miim_rddata), .miim_rddata_valid(miim_rddata_valid),
    .miim_rderr(miim_rderr), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
    .mdio_i(mdio_i)
  );

  always #5 clk = ~clk;

  // PHY model
  logic [63:0] cap_o;
  logic [63:0] cap_oe;
  int          mon_idx = 0;
  int          vld_cnt = 0;
  logic        phy_en = 1'b1;
  logic [15:0] phy_regs [32];

  always @(posedge mdc) begin
    logic [15:0] rv;
    if (mon_idx < 64) begin
      cap_o[63-mon_idx]  = mdio_o;
      cap_oe[63-mon_idx] = mdio_oe;
    end
    mon_idx++;
    if (mon_idx == 64 && cap_o[29:28] == 2'b01 && cap_o[27:23] == 5'd0)
      phy_regs[cap_o[22:18]] = cap_o[15:0];
    rv = phy_regs[cap_o[22:18]];
    if (phy_en && mon_idx >= 47 && mon_idx <= 63 &&
        cap_o[29:28] == 2'b10 && cap_o[27:23] == 5'd0) begin
      if (mon_idx == 47) mdio_i = 1'b0;
      else               mdio_i = rv[63-mon_idx];
    end else begin
      mdio_i = 1'b1;
    end
  end

  always @(negedge clk) if (miim_rddata_valid === 1'b1) vld_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wr_frame(input logic [4:0] pa, input logic [4:0] ra,
                                           input logic [15:0] d);
    return {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, d};
  endfunction

  function automatic logic [45:0] rd_hdr(input logic [4:0] pa, input logic [4:0] ra);
    return {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra};
  endfunction

  // Called at a negedge; drives the pulse for exactly one rising edge.
  task automatic start_req(input logic wr, input logic rd, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd);
    mon_idx     = 0;
    cap_o       = '0;
    cap_oe      = '0;
    miim_wren   = wr;
    miim_rden   = rd;
    miim_phyad  = pa;
    miim_regad  = ra;
    miim_wrdata = wd;
    @(negedge clk);
    miim_wren = 1'b0;
    miim_rden = 1'b0;
    chk("busy_after_pulse", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  int cyc;

  initial begin
    for (int i = 0; i < 32; i++) phy_regs[i] = 16'h0000;
    phy_regs[2] = 16'h0283;

    // reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mdc", 64'(mdc), 64'd0);
    chk("rst_mdio_o", 64'(mdio_o), 64'd1);
    chk("rst_mdio_oe", 64'(mdio_oe), 64'd0);
    chk("rst_rddata", 64'(miim_rddata), 64'd0);
    chk("rst_valid", 64'(miim_rddata_valid), 64'd0);
    chk("rst_rderr", 64'(miim_rderr), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: write reg0 = 0x0044
    vld_cnt = 0;
    start_req(1'b1, 1'b0, 5'd0, 5'd0, 16'h0044);
    wait_idle(cyc);
    chk("t1_busy_len", 64'(cyc), 64'd513);
    chk("t1_bits", 64'(mon_idx), 64'd64);
    chk("t1_frame", cap_o, wr_frame(5'd0, 5'd0, 16'h0044));
    chk("t1_oe", cap_oe, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_no_valid", 64'(vld_cnt), 64'd0);

    // 2: read reg2 from present PHY
    vld_cnt = 0;
    start_req(1'b0, 1'b1, 5'd0, 5'd2, 16'h0000);
    wait_idle(cyc);
    chk("t2_busy_len", 64'(cyc), 64'd513);
    chk("t2_hdr", 64'(cap_o[63:18]), 64'(rd_hdr(5'd0, 5'd2)));
    chk("t2_oe", cap_oe, 64'hFFFF_FFFF_FFFC_0000);
    chk("t2_rddata", 64'(miim_rddata), 64'h0283);
    chk("t2_rderr", 64'(miim_rderr), 64'd0);
    chk("t2_valid_cnt", 64'(vld_cnt), 64'd1);

    // 3: read with no PHY
    phy_en = 1'b0;
    vld_cnt = 0;
    start_req(1'b0, 1'b1, 5'd0, 5'd2, 16'h0000);
    wait_idle(cyc);
    chk("t3_rddata", 64'(miim_rddata), 64'hFFFF);
    chk("t3_rderr", 64'(miim_rderr), 64'd1);
    chk("t3_valid_cnt", 64'(vld_cnt), 64'd1);
    phy_en = 1'b1;

    // 4a: write request during an active frame is dropped
    start_req(1'b1, 1'b0, 5'd0, 5'd0, 16'h0044);
    for (int i = 0; i < 2000 && mon_idx < 21; i++) @(negedge clk);
    chk("t4_reach_bit20", 64'(mon_idx), 64'd21);
    miim_wren = 1'b1; miim_regad = 5'd7; miim_wrdata = 16'hBEEF;
    @(negedge clk);
    miim_wren = 1'b0;
    wait_idle(cyc);
    chk("t4_frame", cap_o, wr_frame(5'd0, 5'd0, 16'h0044));
    for (int i = 0; i < 50; i++) @(negedge clk);
    chk("t4_one_frame", 64'(mon_idx), 64'd64);
    chk("t4_idle", 64'(busy), 64'd0);

    // 4b: simultaneous wren+rden -> write only
    vld_cnt = 0;
    start_req(1'b1, 1'b1, 5'd0, 5'd3, 16'h1234);
    wait_idle(cyc);
    chk("t4b_frame", cap_o, wr_frame(5'd0, 5'd3, 16'h1234));
    chk("t4b_no_valid", 64'(vld_cnt), 64'd0);
    chk("t4b_rddata_kept", 64'(miim_rddata), 64'hFFFF);

    // 5: reset mid-frame
    start_req(1'b1, 1'b0, 5'd0, 5'd0, 16'hDEAD);
    for (int i = 0; i < 2000 && mon_idx < 21; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_mdc", 64'(mdc), 64'd0);
    chk("t5_mdio_oe", 64'(mdio_oe), 64'd0);
    chk("t5_mdio_o", 64'(mdio_o), 64'd1);
    chk("t5_rddata", 64'(miim_rddata), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_req(1'b1, 1'b0, 5'd0, 5'd1, 16'hA5A5);
    wait_idle(cyc);
    chk("t5_busy_len", 64'(cyc), 64'd513);
    chk("t5_frame", cap_o, wr_frame(5'd0, 5'd1, 16'hA5A5));
    chk("t5_oe", cap_oe, 64'hFFFF_FFFF_FFFF_FFFF);

    // 6: back-to-back requests on busy fall
    @(negedge clk);
    vld_cnt = 0;
    start_req(1'b1, 1'b0, 5'd0, 5'd0, 16'h0044);
    wait_idle(cyc);
    chk("t6_w_len", 64'(cyc), 64'd513);
    start_req(1'b0, 1'b1, 5'd0, 5'd2, 16'h0000);
    wait_idle(cyc);
    chk("t6_r2_len", 64'(cyc), 64'd513);
    chk("t6_r2_data", 64'(miim_rddata), 64'h0283);
    start_req(1'b0, 1'b1, 5'd0, 5'd0, 16'h0000);
    wait_idle(cyc);
    chk("t6_r0_len", 64'(cyc), 64'd513);
    chk("t6_r0_data", 64'(miim_rddata), 64'h0044);
    chk("t6_r0_rderr", 64'(miim_rderr), 64'd0);
    chk("t6_valid_cnt", 64'(vld_cnt), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
